wb_addr_decoder: RTL and testbench

WB_ADDR_DECODER -- requirements
Module: wb_addr_decoder

---
 rtl/wb_addr_decoder.sv | 155 +++++++++++++++
 tb/tb_wb_addr_decoder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_addr_decoder.sv
// Wishbone address decoder: routes one master request at a time to one of eight
// mask/base-matched slave regions, with a slave wait timeout and an abort path.
module wb_addr_decoder #(
    parameter int unsigned ADDR_WIDTH     = 64,
    parameter int unsigned DATA_WIDTH     = 64,
    parameter logic [319:0] REGION_BASE   = {40'hFF_F000_0000, 40'h00_0600_0000,
                                             40'h00_0500_0000, 40'h00_0400_0000,
                                             40'h00_0300_0000, 40'h00_0200_0000,
                                             40'h00_0100_0000, 40'h00_0000_0000},
    parameter logic [319:0] REGION_MASK   = {40'hFF_FFFF_F000, 40'hFF_FF00_0000,
                                             40'hFF_FF00_0000, 40'hFF_FF00_0000,
                                             40'hFF_FF00_0000, 40'hFF_FF00_0000,
                                             40'hFF_FF00_0000, 40'hFF_FF00_0000},
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      sys_clock_i,
    input  logic                      sys_reset_i,
    input  logic                      wbm_cycle_i,
    input  logic                      wbm_strobe_i,
    input  logic                      wbm_we_i,
    input  logic [ADDR_WIDTH-1:0]     wbm_addr_i,
    input  logic [DATA_WIDTH-1:0]     wbm_data_i,
    input  logic [DATA_WIDTH/8-1:0]   wbm_sel_i,
    output logic                      wbm_ack_o,
    output logic                      wbm_err_o,
    output logic [DATA_WIDTH-1:0]     wbm_data_o,
    output logic [7:0]                wbs_cycle_o,
    output logic [7:0]                wbs_strobe_o,
    output logic                      wbs_we_o,
    output logic [ADDR_WIDTH-1:0]     wbs_addr_o,
    output logic [DATA_WIDTH-1:0]     wbs_data_o,
    output logic [DATA_WIDTH/8-1:0]   wbs_sel_o,
    input  logic [7:0]                wbs_ack_i,
    input  logic [8*DATA_WIDTH-1:0]   wbs_data_i,
    output logic                      stray_ack_o
);
    localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned SW = DATA_WIDTH / 8;

    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DONE, ST_ERR} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [SW-1:0]         sel_q;
    logic                  we_q;
    logic [2:0]            idx_q;
    logic [7:0]            slv_q;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  ack_q;
    logic                  err_q;
    logic                  stray_q;

    logic                  hit;
    logic [2:0]            hit_idx;
    logic [7:0]            idx_onehot;
    logic [7:0]            ack_foreign;
    logic                  ack_sel;
    logic [DATA_WIDTH-1:0] rd_slice;

    // Scan upward and keep the first match so the lowest region index wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned n = 0; n < 8; n++) begin
            if (!hit && ((wbm_addr_i[39:0] & REGION_MASK[40*n +: 40]) ==
                         (REGION_BASE[40*n +: 40] & REGION_MASK[40*n +: 40]))) begin
                hit     = 1'b1;
                hit_idx = 3'(n);
            end
        end
    end

    always_comb begin
        idx_onehot  = 8'b1 << idx_q;
        ack_sel     = wbs_ack_i[idx_q];
        rd_slice    = wbs_data_i[idx_q*DATA_WIDTH +: DATA_WIDTH];
        ack_foreign = (state_q == ST_ACTIVE) ? (wbs_ack_i & ~idx_onehot) : wbs_ack_i;
        cnt_d       = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
    end

    always_ff @(posedge sys_clock_i) begin
        if (sys_reset_i) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            slv_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            stray_q <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            if (|ack_foreign) stray_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (wbm_cycle_i && wbm_strobe_i) begin
                        addr_q  <= wbm_addr_i;
                        wdata_q <= wbm_data_i;
                        sel_q   <= wbm_sel_i;
                        we_q    <= wbm_we_i;
                        idx_q   <= hit_idx;
                        if (hit) begin
                            slv_q   <= 8'b1 << hit_idx;
                            cnt_q   <= '0;
                            state_q <= ST_ACTIVE;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= ST_ERR;
                        end
                    end
                end
                ST_ACTIVE: begin
                    cnt_q <= cnt_d;
                    // Abort beats a same-cycle ack; an ack beats a same-cycle timeout.
                    if (!wbm_cycle_i) begin
                        slv_q   <= '0;
                        state_q <= ST_IDLE;
                    end else if (ack_sel) begin
                        rdata_q <= rd_slice;
                        slv_q   <= '0;
                        ack_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end else if (cnt_d == CW'(TIMEOUT_CYCLES)) begin
                        slv_q   <= '0;
                        err_q   <= 1'b1;
                        state_q <= ST_ERR;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                ST_ERR:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign wbm_ack_o    = ack_q;
    assign wbm_err_o    = err_q;
    assign wbm_data_o   = rdata_q;
    assign wbs_cycle_o  = slv_q;
    assign wbs_strobe_o = slv_q;
    assign wbs_we_o     = we_q;
    assign wbs_addr_o   = addr_q;
    assign wbs_data_o   = wdata_q;
    assign wbs_sel_o    = sel_q;
    assign stray_ack_o  = stray_q;

endmodule

// File: tb/tb_wb_addr_decoder.sv
// Directed-vector bench for wb_addr_decoder with default region map and timeout.
module tb_wb_addr_decoder;
    logic         clk = 1'b0;
    logic         rst;
    logic         m_cyc, m_stb, m_we;
    logic [63:0]  m_addr, m_wdata;
    logic [7:0]   m_sel;
    logic         m_ack, m_err;
    logic [63:0]  m_rdata;
    logic [7:0]   s_cyc, s_stb;
    logic         s_we;
    logic [63:0]  s_addr, s_wdata;
    logic [7:0]   s_sel;
    logic [7:0]   s_ack;
    logic [511:0] s_rdata;
    logic         stray;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned held;

    wb_addr_decoder #(.TIMEOUT_CYCLES(255)) dut (
        .sys_clock_i (clk),     .sys_reset_i (rst),
        .wbm_cycle_i (m_cyc),   .wbm_strobe_i(m_stb),   .wbm_we_i   (m_we),
        .wbm_addr_i  (m_addr),  .wbm_data_i  (m_wdata), .wbm_sel_i  (m_sel),
        .wbm_ack_o   (m_ack),   .wbm_err_o   (m_err),   .wbm_data_o (m_rdata),
        .wbs_cycle_o (s_cyc),   .wbs_strobe_o(s_stb),   .wbs_we_o   (s_we),
        .wbs_addr_o  (s_addr),  .wbs_data_o  (s_wdata), .wbs_sel_o  (s_sel),
        .wbs_ack_i   (s_ack),   .wbs_data_i  (s_rdata), .stray_ack_o(stray)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [63:0] a, input logic we, input logic [63:0] d, input logic [7:0] s);
        m_cyc = 1'b1; m_stb = 1'b1; m_we = we; m_addr = a; m_wdata = d; m_sel = s;
    endtask

    task automatic release_bus();
        m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
        m_addr = '0; m_wdata = '0; m_sel = '0; s_ack = '0;
        for (int n = 0; n < 8; n++) s_rdata[n*64 +: 64] = 64'hA5A5_0000_0000_0000 | 64'(n);
        tick(); tick();
        chk("rst_ack",   m_ack,   0);
        chk("rst_err",   m_err,   0);
        chk("rst_data",  m_rdata, 0);
        chk("rst_stb",   s_stb,   0);
        chk("rst_addr",  s_addr,  0);
        chk("rst_stray", stray,   0);
        rst = 1'b0;
        tick();

        // Read from region 7, slave acks three cycles after strobe.
        s_rdata[7*64 +: 64] = 64'h0100_0000_0100_0000;
        request(64'hFF_F000_0010, 1'b0, '0, 8'hFF);
        tick();
        chk("rd_stb_t1", s_stb, 8'h80);
        chk("rd_cyc_t1", s_cyc, 8'h80);
        tick();
        chk("rd_noack_t2", m_ack, 0);
        tick();
        tick();
        s_ack = 8'h80;
        tick();
        s_ack = '0; release_bus();
        chk("rd_ack_t5",  m_ack,   1);
        chk("rd_data_t5", m_rdata, 64'h0100_0000_0100_0000);
        chk("rd_stb_off", s_stb,   0);
        tick();
        chk("rd_ack_once", m_ack, 0);
        chk("rd_stray",    stray, 0);

        // Write to region 0; latched request must survive master bus changes.
        request(64'h00_0004_0008, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F);
        tick();
        chk("wr_stb",   s_stb,   8'h01);
        chk("wr_we",    s_we,    1);
        chk("wr_sel",   s_sel,   8'h0F);
        chk("wr_addr",  s_addr,  64'h00_0004_0008);
        chk("wr_wdata", s_wdata, 64'hDEAD_BEEF_CAFE_F00D);
        m_addr = 64'h123; m_wdata = '0; m_sel = 8'hF0;
        s_ack = 8'h01;
        tick();
        s_ack = '0; release_bus();
        chk("wr_ack",      m_ack,  1);
        chk("wr_addr_hold", s_addr, 64'h00_0004_0008);
        tick();
        chk("wr_ack_once", m_ack, 0);
        chk("wr_stb_off",  s_stb, 0);

        // Decode miss.
        request(64'h20_0000_0000, 1'b0, '0, 8'hFF);
        tick();
        release_bus();
        chk("miss_err",  m_err,   1);
        chk("miss_ack",  m_ack,   0);
        chk("miss_stb",  s_stb,   0);
        chk("miss_hold", m_rdata, 64'hA5A5_0000_0000_0000);
        tick();
        chk("miss_err_once", m_err, 0);
        chk("miss_stb2",     s_stb, 0);

        // Timeout: strobe held TIMEOUT_CYCLES cycles, then one err pulse.
        request(64'hFF_F000_0010, 1'b0, '0, 8'hFF);
        tick();
        held = 0;
        while (s_stb == 8'h80 && held < 300) begin
            held++;
            tick();
        end
        release_bus();
        chk("to_held", 64'(held), 255);
        chk("to_err",  m_err,     1);
        chk("to_ack",  m_ack,     0);
        tick();
        chk("to_err_once", m_err, 0);

        // Ack in the final cycle before timeout wins.
        request(64'hFF_F000_0020, 1'b0, '0, 8'hFF);
        tick();
        repeat (254) tick();
        chk("tp_stb_last", s_stb, 8'h80);
        s_ack = 8'h80;
        tick();
        s_ack = '0; release_bus();
        chk("tp_ack", m_ack, 1);
        chk("tp_err", m_err, 0);
        tick();

        // Master abort two cycles into ACTIVE.
        request(64'h00_0000_0100, 1'b0, '0, 8'hFF);
        tick();
        tick();
        release_bus();
        tick();
        chk("ab_stb",  s_stb, 0);
        chk("ab_ack",  m_ack, 0);
        chk("ab_err",  m_err, 0);
        tick();
        chk("ab_ack2", m_ack, 0);
        chk("ab_err2", m_err, 0);
        request(64'h00_0100_0040, 1'b0, '0, 8'hFF);
        tick();
        chk("ab_next_stb", s_stb, 8'h02);
        s_ack = 8'h02;
        tick();
        s_ack = '0; release_bus();
        chk("ab_next_ack",  m_ack,   1);
        chk("ab_next_data", m_rdata, 64'hA5A5_0000_0000_0001);
        tick();

        // Stray ack from region 2 while region 0 is active, then reset mid-ACTIVE.
        request(64'h00_0000_0200, 1'b0, '0, 8'hFF);
        tick();
        s_ack = 8'h04;
        tick();
        s_ack = '0;
        chk("st_stray",   stray, 1);
        chk("st_pending", s_stb, 8'h01);
        chk("st_noack",   m_ack, 0);
        rst = 1'b1;
        tick();
        chk("rr_stb",   s_stb,   0);
        chk("rr_cyc",   s_cyc,   0);
        chk("rr_stray", stray,   0);
        chk("rr_data",  m_rdata, 0);
        chk("rr_addr",  s_addr,  0);
        rst = 1'b0; release_bus();
        tick();
        chk("rr_ack", m_ack, 0);
        chk("rr_err", m_err, 0);

        // Ack while idle also counts as stray.
        s_ack = 8'h10;
        tick();
        s_ack = '0;
        chk("idle_stray", stray, 1);
        chk("idle_ack",   m_ack, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
